bitwise_logic_pipe: RTL and testbench

Parametrised, pipelined successor to the team's combinational bitwise/logical operator block. It takes two WIDTH-bit operands and a 3-bit opcode through a valid/ready handshake. It computes bitwise, logical, inversion-concatenation or sticky-accumulate results, and returns them through a second valid/ready handshake after a fixed 2-stage pipeline. It sits between an operand producer and any result consumer that may apply backpressure.

---
 rtl/bitwise_logic_pipe.sv | 109 ++++++++++
 tb/tb_bitwise_logic_pipe.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_pipe.sv
// Two-stage valid/ready pipeline of bitwise, logical, inversion-concatenation and
// sticky OR-accumulate operations on a pair of WIDTH-bit operands.
module bitwise_logic_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [2:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic               out_logical,
  output logic               out_zero,
  output logic               out_err
);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
  } req_t;

  typedef struct packed {
    logic [2*WIDTH-1:0] result;
    logic               logical;
    logic               zero;
    logic               err;
  } rsp_t;

  logic [STAGES:1]  vld_pipe;
  req_t             s1_q;
  rsp_t             s2_q, s2_d;
  logic [WIDTH-1:0] acc_q, acc_nxt;
  logic             s2_adv, a_nz, b_nz;

  assign s2_adv   = !vld_pipe[2] || out_ready;
  assign in_ready = !vld_pipe[1] || s2_adv;

  assign a_nz = |s1_q.a;
  assign b_nz = |s1_q.b;

  always_comb begin
    s2_d    = '0;
    acc_nxt = acc_q;
    case (s1_q.op)
      3'd0: begin
        s2_d.result  = {{WIDTH{1'b0}}, s1_q.a | s1_q.b};
        s2_d.logical = a_nz || b_nz;
      end
      3'd1: begin
        s2_d.result  = {{WIDTH{1'b0}}, s1_q.a & s1_q.b};
        s2_d.logical = a_nz && b_nz;
      end
      3'd2: begin
        s2_d.result  = {{WIDTH{1'b0}}, s1_q.a ^ s1_q.b};
        s2_d.logical = a_nz ^ b_nz;
      end
      3'd3: begin
        s2_d.result  = {~s1_q.b, ~s1_q.a};
        s2_d.logical = !(a_nz || b_nz);
      end
      3'd4: begin
        s2_d.result  = {{WIDTH{1'b0}}, ~(s1_q.a | s1_q.b)};
        s2_d.logical = !(a_nz || b_nz);
      end
      3'd5: begin
        acc_nxt      = acc_q | s1_q.a;
        s2_d.result  = {{WIDTH{1'b0}}, acc_nxt};
        s2_d.logical = |acc_nxt;
      end
      3'd6: acc_nxt  = '0;
      default: s2_d.err = 1'b1;
    endcase
    s2_d.zero = (s2_d.result == '0);
  end

  // acc only moves together with the S1->S2 transfer, so a stall never replays it
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      acc_q    <= '0;
    end else begin
      if (in_ready) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) s1_q <= '{a: in_a, b: in_b, op: in_op};
      end
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          s2_q  <= s2_d;
          acc_q <= acc_nxt;
        end
      end
    end
  end

  assign out_valid   = vld_pipe[2];
  assign out_result  = s2_q.result;
  assign out_logical = s2_q.logical;
  assign out_zero    = s2_q.zero;
  assign out_err     = s2_q.err;
endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Bench for bitwise_logic_pipe: directed scenarios plus randomized traffic
// scored against an in-order behavioural model with its own accumulator.
module tb_bitwise_logic_pipe;
  logic clk, reset;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_a, in_b;
  logic [2:0]  in_op;
  logic [15:0] out_result;
  logic        out_logical, out_zero, out_err;

  logic        w3_in_valid, w3_in_ready, w3_out_valid, w3_out_ready;
  logic [2:0]  w3_a, w3_b, w3_op;
  logic [5:0]  w3_res;
  logic        w3_lg, w3_z, w3_e;

  bitwise_logic_pipe #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_logical(out_logical),
    .out_zero(out_zero), .out_err(out_err));

  bitwise_logic_pipe #(.WIDTH(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(w3_in_valid), .in_ready(w3_in_ready),
    .in_a(w3_a), .in_b(w3_b), .in_op(w3_op), .out_valid(w3_out_valid),
    .out_ready(w3_out_ready), .out_result(w3_res), .out_logical(w3_lg),
    .out_zero(w3_z), .out_err(w3_e));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] res;
    logic        lg;
    logic        z;
    logic        e;
  } exp_t;

  int checks = 0;
  int errors = 0;

  exp_t       q[$];
  logic [7:0] macc;

  // Observations of the most recent cycle()
  logic o_v, o_ir;
  bit   in_f, out_f, o_had;
  exp_t o_got, o_exp;
  int   o_occ;

  function automatic exp_t model(input logic [7:0] a, b, input logic [2:0] op);
    exp_t r;
    bit an, bn;
    an = (a != 0);
    bn = (b != 0);
    r  = '0;
    case (op)
      3'd0: begin r.res = {8'h00, a | b};     r.lg = an || bn;    end
      3'd1: begin r.res = {8'h00, a & b};     r.lg = an && bn;    end
      3'd2: begin r.res = {8'h00, a ^ b};     r.lg = an != bn;    end
      3'd3: begin r.res = {~b, ~a};           r.lg = !(an || bn); end
      3'd4: begin r.res = {8'h00, ~(a | b)};  r.lg = !(an || bn); end
      3'd5: begin macc = macc | a; r.res = {8'h00, macc}; r.lg = (macc != 0); end
      3'd6: begin macc = 8'h00; end
      default: r.e = 1'b1;
    endcase
    r.z = (r.res == 16'h0000);
    return r;
  endfunction

  // Drive one cycle at negedge, sample just after, keep scoreboard in step
  task automatic cycle(input bit v, input logic [7:0] a, b, input logic [2:0] op, input bit rdy);
    @(negedge clk);
    in_valid = v; in_a = a; in_b = b; in_op = op; out_ready = rdy;
    #1;
    o_v   = out_valid;
    o_ir  = in_ready;
    o_got = {out_result, out_logical, out_zero, out_err};
    o_occ = q.size();
    in_f  = v && o_ir;
    out_f = o_v && rdy;
    o_had = 0;
    if (out_f && q.size() > 0) begin o_exp = q.pop_front(); o_had = 1; end
    if (in_f) q.push_back(model(a, b, op));
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1; in_valid = 1; in_a = 8'hAA; in_b = 8'h55; in_op = 3'd0; out_ready = 1;
    w3_in_valid = 1; w3_a = 3'b111; w3_b = 3'b001; w3_op = 3'd0; w3_out_ready = 1;
    repeat (2) @(negedge clk);
    reset = 0; in_valid = 0; w3_in_valid = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if ({out_result, out_logical, out_zero, out_err} !== 19'd0) begin
      errors++; $display("FAIL reset_outputs got res=%h lg=%b z=%b e=%b want all 0", out_result, out_logical, out_zero, out_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (w3_out_valid !== 1'b0 || w3_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_w3 got ov=%b ir=%b want 0/1", w3_out_valid, w3_in_ready); end
    repeat (3) begin
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b0 || w3_out_valid !== 1'b0) begin
        errors++; $display("FAIL reset_beat_leak got ov=%b w3ov=%b want 0", out_valid, w3_out_valid); end
    end
    q.delete(); macc = 8'h00;
  endtask

  task automatic test_w3;
    @(negedge clk); w3_in_valid = 1; w3_a = 3'b101; w3_b = 3'b000; w3_op = 3'd0; w3_out_ready = 1;
    @(negedge clk); w3_in_valid = 0; #1;
    checks++; if (w3_out_valid !== 1'b0) begin errors++; $display("FAIL w3_latency_early got ov=%b want 0", w3_out_valid); end
    @(negedge clk); #1;
    checks++; if ({w3_out_valid, w3_res, w3_lg, w3_z, w3_e} !== {1'b1, 6'h05, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL w3_or got ov=%b res=%h lg=%b z=%b e=%b want 1 05 1 0 0", w3_out_valid, w3_res, w3_lg, w3_z, w3_e); end
    w3_in_valid = 1; w3_a = 3'b101; w3_b = 3'b010; w3_op = 3'd3;
    @(negedge clk); w3_in_valid = 0;
    @(negedge clk); #1;
    checks++; if ({w3_out_valid, w3_res, w3_lg, w3_z, w3_e} !== {1'b1, 6'b101_010, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL w3_not got ov=%b res=%b lg=%b z=%b e=%b want 1 101010 0 0 0", w3_out_valid, w3_res, w3_lg, w3_z, w3_e); end
    @(negedge clk); #1;
    checks++; if (w3_out_valid !== 1'b0) begin errors++; $display("FAIL w3_drain got ov=%b want 0", w3_out_valid); end
  endtask

  task automatic test_acc;
    logic [7:0] ta [5] = '{8'h01, 8'h10, 8'h80, 8'h00, 8'h02};
    logic [2:0] to [5] = '{3'd5, 3'd5, 3'd5, 3'd6, 3'd5};
    logic [7:0] er [5] = '{8'h01, 8'h11, 8'h91, 8'h00, 8'h02};
    logic       el [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_t got [5];
    int sent = 0, ngot = 0, cyc = 0;
    while ((sent < 5 || q.size() > 0) && cyc < 50) begin
      if (sent < 5) cycle(1, ta[sent], 8'($urandom), to[sent], 1);
      else          cycle(0, 8'h00, 8'h00, 3'd0, 1);
      if (in_f) sent++;
      if (out_f) begin if (ngot < 5) got[ngot] = o_got; ngot++; end
      cyc++;
    end
    checks++; if (ngot != 5) begin errors++; $display("FAIL acc_count got %0d want 5", ngot); end
    for (int i = 0; i < 5 && i < ngot; i++) begin
      checks++;
      if (got[i].res !== {8'h00, er[i]} || got[i].lg !== el[i] || got[i].e !== 1'b0) begin
        errors++; $display("FAIL acc_seq[%0d] got res=%h lg=%b e=%b want %h %b 0", i, got[i].res, got[i].lg, got[i].e, er[i], el[i]); end
    end
  endtask

  task automatic test_backpressure;
    int sent = 0, ngot = 0, cyc = 0;
    bit rdy, pstall = 0;
    exp_t pgot;
    while ((sent < 10 || q.size() > 0) && cyc < 100) begin
      rdy = (cyc % 3 == 0);
      if (sent < 10) cycle(1, 8'($urandom), 8'($urandom), 3'd0, rdy);
      else           cycle(0, 8'h00, 8'h00, 3'd0, rdy);
      checks++; if (o_ir !== !(o_occ == 2 && !rdy)) begin
        errors++; $display("FAIL bp_in_ready cyc=%0d got %b want %b", cyc, o_ir, !(o_occ == 2 && !rdy)); end
      if (pstall) begin
        checks++; if (o_v !== 1'b1 || o_got !== pgot) begin
          errors++; $display("FAIL bp_stall_hold cyc=%0d got ov=%b %h want 1 %h", cyc, o_v, o_got, pgot); end
      end
      if (out_f) begin
        ngot++;
        checks++; if (!o_had || o_got !== o_exp) begin
          errors++; $display("FAIL bp_result cyc=%0d got %h want %h (had=%0d)", cyc, o_got, o_exp, o_had); end
      end
      if (in_f) sent++;
      pstall = o_v && !rdy;
      pgot   = o_got;
      cyc++;
    end
    checks++; if (ngot != 10 || q.size() != 0) begin
      errors++; $display("FAIL bp_delivered got %0d left %0d want 10 0", ngot, q.size()); end
  endtask

  task automatic test_reserved;
    logic [7:0] r = 8'($urandom_range(1, 255));
    logic [7:0] ta [4];
    logic [2:0] to [4] = '{3'd6, 3'd5, 3'd7, 3'd5};
    exp_t got [4];
    int sent = 0, ngot = 0, cyc = 0;
    ta = '{8'h00, r, 8'($urandom), 8'h00};
    while ((sent < 4 || q.size() > 0) && cyc < 50) begin
      if (sent < 4) cycle(1, ta[sent], 8'($urandom), to[sent], 1);
      else          cycle(0, 8'h00, 8'h00, 3'd0, 1);
      if (in_f) sent++;
      if (out_f) begin if (ngot < 4) got[ngot] = o_got; ngot++; end
      cyc++;
    end
    checks++; if (ngot != 4) begin errors++; $display("FAIL rsv_count got %0d want 4", ngot); end
    else begin
      checks++; if (got[2] !== {16'h0000, 1'b0, 1'b1, 1'b1}) begin
        errors++; $display("FAIL rsv_op7 got res=%h lg=%b z=%b e=%b want 0000 0 1 1", got[2].res, got[2].lg, got[2].z, got[2].e); end
      checks++; if (got[3] !== {8'h00, r, 1'b1, 1'b0, 1'b0}) begin
        errors++; $display("FAIL rsv_acc_kept got res=%h lg=%b e=%b want %h 1 0", got[3].res, got[3].lg, got[3].e, r); end
    end
  endtask

  task automatic test_reset_midflight;
    int ngot = 0, cyc = 0;
    bit sent = 0;
    cycle(1, 8'hFF, 8'($urandom), 3'd5, 0);
    cycle(1, 8'h0F, 8'($urandom), 3'd5, 0);
    @(negedge clk); reset = 1; in_valid = 0; out_ready = 0;
    @(negedge clk); reset = 0; #1;
    checks++; if (out_valid !== 1'b0 || out_result !== 16'h0000 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset got ov=%b res=%h ir=%b want 0 0000 1", out_valid, out_result, in_ready); end
    q.delete(); macc = 8'h00;
    while ((!sent || q.size() > 0) && cyc < 50) begin
      if (!sent) cycle(1, 8'h04, 8'($urandom), 3'd5, 1);
      else       cycle(0, 8'h00, 8'h00, 3'd0, 1);
      if (in_f) sent = 1;
      if (out_f) begin
        ngot++;
        checks++; if (o_got.res !== 16'h0004 || o_got.lg !== 1'b1) begin
          errors++; $display("FAIL mid_acc_cleared got res=%h lg=%b want 0004 1", o_got.res, o_got.lg); end
      end
      cyc++;
    end
    checks++; if (ngot != 1) begin errors++; $display("FAIL mid_count got %0d want 1", ngot); end
  endtask

  task automatic test_random;
    int sent = 0, ngot = 0, cyc = 0;
    bit v, rdy, pstall = 0;
    exp_t pgot;
    logic [7:0] a, b;
    while ((sent < 300 || q.size() > 0) && cyc < 2000) begin
      v   = (sent < 300) && ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 9) < 7);
      a   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      cycle(v, a, b, 3'($urandom), rdy);
      checks++; if (o_ir !== !(o_occ == 2 && !rdy)) begin
        errors++; $display("FAIL rnd_in_ready cyc=%0d got %b want %b", cyc, o_ir, !(o_occ == 2 && !rdy)); end
      if (pstall) begin
        checks++; if (o_v !== 1'b1 || o_got !== pgot) begin
          errors++; $display("FAIL rnd_stall_hold cyc=%0d got ov=%b %h want 1 %h", cyc, o_v, o_got, pgot); end
      end
      if (out_f) begin
        ngot++;
        checks++; if (!o_had || o_got !== o_exp) begin
          errors++; $display("FAIL rnd_result cyc=%0d got %h want %h (had=%0d)", cyc, o_got, o_exp, o_had); end
      end
      if (in_f) sent++;
      pstall = o_v && !rdy;
      pgot   = o_got;
      cyc++;
    end
    checks++; if (sent != 300 || ngot != 300) begin
      errors++; $display("FAIL rnd_delivered sent %0d got %0d want 300 300", sent, ngot); end
  endtask

  initial begin
    clk = 0; reset = 1;
    in_valid = 0; in_a = 0; in_b = 0; in_op = 0; out_ready = 0;
    w3_in_valid = 0; w3_a = 0; w3_b = 0; w3_op = 0; w3_out_ready = 0;
    macc = 8'h00;
    test_reset;
    test_w3;
    test_acc;
    test_backpressure;
    test_reserved;
    test_reset_midflight;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
